// File: rtl/step_counter_pkg.sv
// Shared constants for the step counter: the two bound-handling modes.
package step_counter_pkg;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;
endpackage

// File: rtl/step_counter_if.sv
// Control/status bundle of the step counter; suffixes are from the counter's point of view.
interface step_counter_if #(
  parameter int WIDTH = 3
);
  logic             en_i;
  logic             up_i;
  logic             mode_i;
  logic [WIDTH-1:0] step_i;
  logic [WIDTH-1:0] limit_i;
  logic             load_i;
  logic [WIDTH-1:0] load_val_i;
  logic [WIDTH-1:0] out_o;
  logic             wrap_pulse_o;
  logic             at_bound_o;

  modport master (
    output en_i, up_i, mode_i, step_i, limit_i, load_i, load_val_i,
    input  out_o, wrap_pulse_o, at_bound_o
  );

  modport slave (
    input  en_i, up_i, mode_i, step_i, limit_i, load_i, load_val_i,
    output out_o, wrap_pulse_o, at_bound_o
  );
endinterface

// File: rtl/step_counter_next.sv
// Combinational next-count and wrap/saturate-event decode for one enabled step.
module step_counter_next
  import step_counter_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] out_i,
  input  logic [WIDTH-1:0] step_i,
  input  logic [WIDTH-1:0] limit_i,
  input  logic             up_i,
  input  logic             mode_i,
  output logic [WIDTH-1:0] nxt_o,
  output logic             wrap_evt_o
);
  // One extra bit so out+step can be compared to limit without overflowing.
  logic [WIDTH:0] sum;
  assign sum = {1'b0, out_i} + {1'b0, step_i};

  always_comb begin
    nxt_o      = out_i;
    wrap_evt_o = 1'b0;
    if (up_i) begin
      if (out_i >= limit_i) begin
        if (mode_i == MODE_WRAP) begin
          nxt_o      = '0;
          wrap_evt_o = 1'b1;
        end else begin
          // Saturating: only a count pulled down onto the limit signals the hit.
          nxt_o      = limit_i;
          wrap_evt_o = (out_i != limit_i);
        end
      end else if (sum > {1'b0, limit_i}) begin
        nxt_o = limit_i;
      end else begin
        nxt_o = sum[WIDTH-1:0];
      end
    end else begin
      if (out_i == '0) begin
        if (mode_i == MODE_WRAP) begin
          nxt_o      = limit_i;
          wrap_evt_o = 1'b1;
        end
      end else if (out_i < step_i) begin
        nxt_o = '0;
      end else begin
        nxt_o = out_i - step_i;
      end
    end
  end
endmodule

// File: rtl/step_counter.sv
// Up/down counter stepping by a run-time amount between 0 and a run-time limit,
// with load, enable, registered wrap pulse and combinational bound flag.
module step_counter
  import step_counter_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input logic          clk,
  input logic          rst,
  step_counter_if.slave bus
);
  logic [WIDTH-1:0] out_q, out_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] step_nxt;
  logic             step_evt;

  step_counter_next #(.WIDTH(WIDTH)) u_next (
    .out_i      (out_q),
    .step_i     (bus.step_i),
    .limit_i    (bus.limit_i),
    .up_i       (bus.up_i),
    .mode_i     (bus.mode_i),
    .nxt_o      (step_nxt),
    .wrap_evt_o (step_evt)
  );

  // Load beats enable; an idle cycle holds the count and drops the pulse.
  always_comb begin
    out_d  = out_q;
    wrap_d = 1'b0;
    if (bus.load_i) begin
      out_d = bus.load_val_i;
    end else if (bus.en_i) begin
      out_d  = step_nxt;
      wrap_d = step_evt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.out_o        = out_q;
  assign bus.wrap_pulse_o = wrap_q;
  assign bus.at_bound_o   = (bus.up_i & (out_q >= bus.limit_i)) | (~bus.up_i & (out_q == '0));
endmodule

// File: tb/tb_step_counter.sv
// Directed vector bench for step_counter (WIDTH 3, plus a WIDTH 8 overflow check).
module tb_step_counter;
  import step_counter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  step_counter_if #(.WIDTH(3)) bus3 ();
  step_counter_if #(.WIDTH(8)) bus8 ();

  step_counter #(.WIDTH(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));
  step_counter #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

  typedef struct {
    string      name;
    logic       load;
    logic [2:0] load_val;
    logic       en;
    logic       up;
    logic       mode;
    logic [2:0] step;
    logic [2:0] limit;
    logic [2:0] exp_out;
    logic       exp_pulse;
    logic       exp_ab;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  function automatic void add(string n, logic ld, logic [2:0] lv, logic en, logic up,
                              logic mode, logic [2:0] st, logic [2:0] lim,
                              logic [2:0] eo, logic ep, logic eab);
    vec_t v;
    v.name = n; v.load = ld; v.load_val = lv; v.en = en; v.up = up; v.mode = mode;
    v.step = st; v.limit = lim; v.exp_out = eo; v.exp_pulse = ep; v.exp_ab = eab;
    vecs.push_back(v);
  endfunction

  task automatic check(string n, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", n, act, exp);
    end
  endtask

  task automatic drive3(vec_t v);
    bus3.load_i = v.load; bus3.load_val_i = v.load_val; bus3.en_i = v.en;
    bus3.up_i = v.up; bus3.mode_i = v.mode; bus3.step_i = v.step; bus3.limit_i = v.limit;
  endtask

  initial begin
    bus3.load_i = 0; bus3.load_val_i = 0; bus3.en_i = 0; bus3.up_i = 1;
    bus3.mode_i = MODE_WRAP; bus3.step_i = 0; bus3.limit_i = 6;
    bus8.load_i = 0; bus8.load_val_i = 0; bus8.en_i = 0; bus8.up_i = 1;
    bus8.mode_i = MODE_WRAP; bus8.step_i = 0; bus8.limit_i = 0;

    //  name          ld lv en up mode       st lim  out pulse ab
    add("t1_up2",      0, 0, 1, 1, MODE_WRAP, 2, 6,   2, 0, 0);
    add("t1_up4",      0, 0, 1, 1, MODE_WRAP, 2, 6,   4, 0, 0);
    add("t1_up6",      0, 0, 1, 1, MODE_WRAP, 2, 6,   6, 0, 1);
    add("t1_wrap0",    0, 0, 1, 1, MODE_WRAP, 2, 6,   0, 1, 0);
    add("t1_up2b",     0, 0, 1, 1, MODE_WRAP, 2, 6,   2, 0, 0);
    add("t2_load0",    1, 0, 0, 1, MODE_WRAP, 3, 7,   0, 0, 0);
    add("t2_up3",      0, 0, 1, 1, MODE_WRAP, 3, 7,   3, 0, 0);
    add("t2_up6",      0, 0, 1, 1, MODE_WRAP, 3, 7,   6, 0, 0);
    add("t2_clamp7",   0, 0, 1, 1, MODE_WRAP, 3, 7,   7, 0, 1);
    add("t2_wrap0",    0, 0, 1, 1, MODE_WRAP, 3, 7,   0, 1, 0);
    add("t3w_load5",   1, 5, 0, 0, MODE_WRAP, 2, 6,   5, 0, 0);
    add("t3w_dn3",     0, 0, 1, 0, MODE_WRAP, 2, 6,   3, 0, 0);
    add("t3w_dn1",     0, 0, 1, 0, MODE_WRAP, 2, 6,   1, 0, 0);
    add("t3w_clamp0",  0, 0, 1, 0, MODE_WRAP, 2, 6,   0, 0, 1);
    add("t3w_wrap6",   0, 0, 1, 0, MODE_WRAP, 2, 6,   6, 1, 0);
    add("t3w_dn4",     0, 0, 1, 0, MODE_WRAP, 2, 6,   4, 0, 0);
    add("t3s_load5",   1, 5, 0, 0, MODE_SAT,  2, 6,   5, 0, 0);
    add("t3s_dn3",     0, 0, 1, 0, MODE_SAT,  2, 6,   3, 0, 0);
    add("t3s_dn1",     0, 0, 1, 0, MODE_SAT,  2, 6,   1, 0, 0);
    add("t3s_clamp0",  0, 0, 1, 0, MODE_SAT,  2, 6,   0, 0, 1);
    add("t3s_hold0a",  0, 0, 1, 0, MODE_SAT,  2, 6,   0, 0, 1);
    add("t3s_hold0b",  0, 0, 1, 0, MODE_SAT,  2, 6,   0, 0, 1);
    add("t4_load_en",  1, 7, 1, 1, MODE_WRAP, 1, 4,   7, 0, 1);
    add("t4_wrap",     0, 0, 1, 1, MODE_WRAP, 1, 4,   0, 1, 0);
    add("sat_load4",   1, 4, 0, 1, MODE_SAT,  1, 4,   4, 0, 1);
    add("sat_at_lim",  0, 0, 1, 1, MODE_SAT,  1, 4,   4, 0, 1);
    add("hold_en0",    0, 0, 0, 1, MODE_SAT,  1, 4,   4, 0, 1);
    add("lim0_load",   1, 0, 0, 1, MODE_WRAP, 1, 0,   0, 0, 1);
    add("lim0_wrapA",  0, 0, 1, 1, MODE_WRAP, 1, 0,   0, 1, 1);
    add("lim0_wrapB",  0, 0, 1, 1, MODE_WRAP, 1, 0,   0, 1, 1);
    add("over_load7",  1, 7, 0, 0, MODE_WRAP, 2, 3,   7, 0, 0);
    add("over_dn5",    0, 0, 1, 0, MODE_WRAP, 2, 3,   5, 0, 0);
    add("step0_hold",  0, 0, 1, 1, MODE_WRAP, 0, 6,   5, 0, 0);
    add("step0_dn0",   1, 0, 0, 0, MODE_WRAP, 0, 6,   0, 0, 1);
    add("step0_wrap",  0, 0, 1, 0, MODE_WRAP, 0, 6,   6, 1, 0);

    // Reset state, checked while rst is still asserted.
    #12;
    check("rst_out", {5'd0, bus3.out_o}, 8'd0);
    check("rst_pulse", {7'd0, bus3.wrap_pulse_o}, 8'd0);
    check("rst_out8", bus8.out_o, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;

    foreach (vecs[i]) begin
      drive3(vecs[i]);
      @(posedge clk);
      #1;
      check({vecs[i].name, "_out"}, {5'd0, bus3.out_o}, {5'd0, vecs[i].exp_out});
      check({vecs[i].name, "_pulse"}, {7'd0, bus3.wrap_pulse_o}, {7'd0, vecs[i].exp_pulse});
      check({vecs[i].name, "_atb"}, {7'd0, bus3.at_bound_o}, {7'd0, vecs[i].exp_ab});
      $display("vec %0d %s: out=%0d pulse=%0d at_bound=%0d", i, vecs[i].name,
               bus3.out_o, bus3.wrap_pulse_o, bus3.at_bound_o);
    end

    // Asynchronous reset mid-cycle while out = 4.
    bus3.load_i = 1; bus3.load_val_i = 4; bus3.en_i = 0; bus3.up_i = 1;
    bus3.mode_i = MODE_WRAP; bus3.step_i = 2; bus3.limit_i = 6;
    @(posedge clk);
    #1;
    check("t5_pre", {5'd0, bus3.out_o}, 8'd4);
    bus3.load_i = 0; bus3.en_i = 1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t5_async_out", {5'd0, bus3.out_o}, 8'd0);
    check("t5_async_pulse", {7'd0, bus3.wrap_pulse_o}, 8'd0);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("t5_first_edge", {5'd0, bus3.out_o}, 8'd2);
    $display("t5: out=%0d after reset release", bus3.out_o);
    bus3.en_i = 0;

    // WIDTH 8: 200 + 200 must clamp to 250, not overflow to 144.
    bus8.en_i = 1; bus8.up_i = 1; bus8.mode_i = MODE_WRAP;
    bus8.step_i = 8'd200; bus8.limit_i = 8'd250;
    @(posedge clk); #1;
    check("t6_out200", bus8.out_o, 8'd200);
    $display("t6: out=%0d", bus8.out_o);
    @(posedge clk); #1;
    check("t6_out250", bus8.out_o, 8'd250);
    check("t6_atb250", {7'd0, bus8.at_bound_o}, 8'd1);
    check("t6_nopulse", {7'd0, bus8.wrap_pulse_o}, 8'd0);
    $display("t6: out=%0d", bus8.out_o);
    @(posedge clk); #1;
    check("t6_out0", bus8.out_o, 8'd0);
    check("t6_pulse", {7'd0, bus8.wrap_pulse_o}, 8'd1);
    $display("t6: out=%0d pulse=%0d", bus8.out_o, bus8.wrap_pulse_o);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
